// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep driver.
package tt_sweep_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int VEC_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tt_sweep_driver_if.sv
// Stimulus/response bundle between the sweep driver and the unit under test.
interface tt_sweep_driver_if;
    import tt_sweep_pkg::*;

    logic                   start;
    logic                   a;
    logic                   b;
    logic                   c;
    logic                   d;
    logic                   y;
    logic                   busy;
    logic                   done;
    logic [NUM_VECTORS-1:0] table_out;
    logic                   pass;
    logic [VEC_W-1:0]       vec_idx;

    // The sweep driver itself.
    modport master (
        input  start, y,
        output a, b, c, d, busy, done, table_out, pass, vec_idx
    );

    // Controller / unit-under-test side.
    modport slave (
        output start, y,
        input  a, b, c, d, busy, done, table_out, pass, vec_idx
    );
endinterface

// File: rtl/tt_sweep_driver_settle_counter.sv
// Per-vector settle timer: flags the final cycle of each hold window.
module settle_counter #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic last
);
    localparam int CW_RAW = $clog2(HOLD_CYCLES + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt;

    // The counter wraps by itself at the end of a window, so the top only
    // needs to clear it when a new sweep is accepted.
    assign last = en && (cnt == LAST_CNT);

    // Count hold cycles while enabled.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/tt_sweep_driver.sv
// Exhaustive 4-input sweep: drives vectors 0..15, captures y per vector
// into a truth table and compares it to a golden table.
module tt_sweep_driver
    import tt_sweep_pkg::*;
#(
    parameter int unsigned          HOLD_CYCLES = 4,
    parameter logic [NUM_VECTORS-1:0] EXPECTED  = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    tt_sweep_driver_if.master  bus
);
    state_t                 state;
    logic [VEC_W-1:0]       vec_idx;
    logic [NUM_VECTORS-1:0] tbl;
    logic                   busy_q;
    logic                   done_q;
    logic                   accept;
    logic                   last;

    // start is only honoured when no sweep is running.
    assign accept = bus.start && (state == IDLE || state == DONE);

    settle_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_settle (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .en    (state == HOLD),
        .last  (last)
    );

    // Sweep FSM with index, capture register and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            vec_idx <= '0;
            tbl     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state   <= HOLD;
                        vec_idx <= '0;
                        tbl     <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (last) begin
                        tbl[vec_idx] <= bus.y;
                        // Index parks at 15 in DONE; only a new start rewinds it.
                        if (vec_idx == VEC_W'(NUM_VECTORS - 1)) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            vec_idx <= vec_idx + VEC_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign {bus.a, bus.b, bus.c, bus.d} = vec_idx;
    assign bus.vec_idx   = vec_idx;
    assign bus.table_out = tbl;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    // Combinational so it is valid in the same cycle done rises.
    assign bus.pass      = done_q && (tbl == EXPECTED);
endmodule
